oram_request_arbiter: RTL

//  Shares one oram_module instance between NUM_REQ client requesters.

---
 rtl/oram_request_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/oram_request_arbiter.sv
// Round-robin arbiter sharing one ORAM port among NUM_REQ requesters.
// Define ORAM_ARB_DUMMY_EN to add idle-time dummy reads every DUMMY_GAP cycles.
module oram_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int D         = 8,
  parameter int A         = 4,
  parameter int DUMMY_GAP = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [NUM_REQ*D-1:0]   req_addr,
  input  logic [NUM_REQ*8*A-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [8*A-1:0]         rsp_rdata,
  output logic [D-1:0]           oram_block_number,
  output logic [8*A-1:0]         oram_w_value,
  output logic                   oram_rw_indicator,
  output logic                   oram_input_ready,
  input  logic [8*A-1:0]         oram_r_value,
  input  logic                   oram_output_ready,
  output logic                   busy
);

  localparam int W  = 8 * A;
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   g_q;
  logic            rw_q;
  logic [D-1:0]    addr_q;
  logic [W-1:0]    wdata_q;
  logic [W-1:0]    rdata_q;

  logic            gnt_vld;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   cand;
  logic [NUM_REQ-1:0] gnt_oh;
  logic            accept;
  logic            dummy_q;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GW'((int'(rr_q) + i) % NUM_REQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_vld;
  end

  assign accept = (state_q == S_IDLE) && gnt_vld;
  assign rr_d   = (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef ORAM_ARB_DUMMY_EN
  localparam int CW = $clog2(DUMMY_GAP + 1);

  logic [CW-1:0] idle_cnt_q;
  logic [D-1:0]  dummy_addr_q;
  logic          dummy_go;

  assign dummy_go = (state_q == S_IDLE) && (req_valid == '0) &&
                    (idle_cnt_q == CW'(DUMMY_GAP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q   <= '0;
      dummy_addr_q <= '0;
      dummy_q      <= 1'b0;
    end else begin
      if (state_q != S_IDLE || req_valid != '0 || dummy_go)
        idle_cnt_q <= '0;
      else
        idle_cnt_q <= idle_cnt_q + 1'b1;
      if (dummy_go) begin
        dummy_addr_q <= dummy_addr_q + 1'b1;
        dummy_q      <= 1'b1;
      end else if (accept) begin
        dummy_q      <= 1'b0;
      end
    end
  end
`else
  assign dummy_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) state_d = S_ISSUE;
`ifdef ORAM_ARB_DUMMY_EN
        else if (dummy_go) state_d = S_ISSUE;
`endif
      end
      S_ISSUE: state_d = S_WAIT;
      // Dummy results are dropped, so RESP is skipped.
      S_WAIT: begin
        if (oram_output_ready)
          state_d = dummy_q ? S_IDLE : S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        g_q     <= gnt_idx;
        rw_q    <= req_rw[gnt_idx];
        addr_q  <= req_addr[int'(gnt_idx)*D +: D];
        wdata_q <= req_wdata[int'(gnt_idx)*W +: W];
        rr_q    <= rr_d;
      end
`ifdef ORAM_ARB_DUMMY_EN
      else if (dummy_go) begin
        rw_q    <= 1'b0;
        addr_q  <= dummy_addr_q;
        wdata_q <= '0;
      end
`endif
      if (state_q == S_WAIT && oram_output_ready && !dummy_q)
        rdata_q <= rw_q ? '0 : oram_r_value;
    end
  end

  always_comb begin
    rsp_valid      = '0;
    rsp_valid[g_q] = (state_q == S_RESP);
  end

  assign req_ready         = (rst_n && state_q == S_IDLE) ? gnt_oh : '0;
  assign rsp_rdata         = rdata_q;
  assign oram_block_number = addr_q;
  assign oram_w_value      = wdata_q;
  assign oram_rw_indicator = rw_q;
  assign oram_input_ready  = (state_q == S_ISSUE);
  assign busy              = (state_q != S_IDLE);

endmodule
